// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants for the RV32I multi-cycle control unit.
//   - opcode constants (instrCode[6:0]) for every supported instruction class
//   - 4-bit ALU operation codes, laid out as {funct7[5], funct3}
//   - register-file write-data source selects
//   - control FSM state enumeration
package rv32i_pkg;

    localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
    localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
    localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
    localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
    localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
    localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
    localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
    localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
    localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b1000;
    localparam logic [3:0] SLL  = 4'b0001;
    localparam logic [3:0] SLT  = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011;
    localparam logic [3:0] XOR  = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] SRA  = 4'b1101;
    localparam logic [3:0] OR   = 4'b0110;
    localparam logic [3:0] AND  = 4'b0111;

    localparam logic [1:0] RFWD_ALU    = 2'b00;
    localparam logic [1:0] RFWD_BUS    = 2'b01;
    localparam logic [1:0] RFWD_PC_IMM = 2'b10;
    localparam logic [1:0] RFWD_PC_4   = 2'b11;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        R_EXE  = 4'd2,
        I_EXE  = 4'd3,
        B_EXE  = 4'd4,
        LU_EXE = 4'd5,
        AU_EXE = 4'd6,
        J_EXE  = 4'd7,
        JL_EXE = 4'd8,
        S_EXE  = 4'd9,
        S_MEM  = 4'd10,
        L_EXE  = 4'd11,
        L_MEM  = 4'd12,
        L_WB   = 4'd13
    } state_e;

    function automatic logic is_mem_state(input state_e s);
        return (s == S_MEM) || (s == L_MEM);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control-unit <-> datapath/bus signal bundle.
//   Inputs to the control unit: instrCode (stable while pcEn=0), busReady.
//   Outputs from the control unit: every datapath select/enable, PC enable,
//   data-bus request/direction and the two error pulses.
// Bus handshake: busReq is held (with busWe giving direction) for every
// cycle of a memory state; the access completes in the first cycle where
// busReq and busReady are both 1. busReady is ignored when busReq is 0.
// Modports: master = control unit, slave = datapath / bus side.
interface multicycle_control_unit_if;
    logic [31:0] instrCode;
    logic        busReady;
    logic        regFileWe;
    logic [3:0]  aluControl;
    logic        aluSrcMuxSel;
    logic [1:0]  RFWDSrcMuxSel;
    logic        RD1MuxSel;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        pcEn;
    logic        busReq;
    logic        busWe;
    logic        illegalInstr;
    logic        busError;

    modport master (
        input  instrCode, busReady,
        output regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel, RD1MuxSel,
               branch, jump, jalr, pcEn, busReq, busWe, illegalInstr, busError
    );

    modport slave (
        output instrCode, busReady,
        input  regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel, RD1MuxSel,
               branch, jump, jalr, pcEn, busReq, busWe, illegalInstr, busError
    );
endinterface

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: combinational ALU operation decode.
//   opcode   in  7  instruction opcode
//   funct3   in  3  instruction funct3
//   funct7_5 in  1  instruction bit 30
//   alu_control out 4  ALU op / branch condition
// Classes that only need address or sum arithmetic (S, L, LU, AU, J, JL)
// decode to ADD.
module mc_alu_decoder
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ADD;
        case (opcode)
            OP_TYPE_R: alu_control = {funct7_5, funct3};
            // Bit 30 is part of the immediate for I-type, except for
            // SRLI/SRAI where it selects arithmetic shift.
            OP_TYPE_I: alu_control = (funct3 == 3'b101) ? {funct7_5, funct3}
                                                        : {1'b0, funct3};
            OP_TYPE_B: alu_control = {1'b0, funct3};
            default:   alu_control = ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RV32I control FSM.
//   clk        in   clock
//   reset      in   synchronous, active-high
//   bus        master modport of multicycle_control_unit_if (all datapath
//              selects/enables, PC enable, bus req/ready, error pulses)
//   state_dbg  out  current FSM state
// Every instruction passes FETCH -> DECODE -> <class>_EXE; stores and loads
// continue through a MEM state (bounded by BUS_TIMEOUT) and loads end in
// L_WB. pcEn is high in exactly one cycle per instruction. Outputs are
// decoded from state and instrCode; in the MEM states pcEn/busError also
// depend on busReady in the same cycle.
module multicycle_control_unit
    import rv32i_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_control_unit_if.master      bus,
    output state_e                         state_dbg
);

    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUS_TIMEOUT - 1);

    state_e           state, state_n;
    logic [CNT_W-1:0] tmo_cnt;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic [3:0]       dec_alu;
    logic             timeout;

    assign opcode    = bus.instrCode[6:0];
    assign funct3    = bus.instrCode[14:12];
    assign funct7_5  = bus.instrCode[30];
    assign state_dbg = state;

    // busReady takes priority over an expiring counter.
    assign timeout = (tmo_cnt == TMO_LAST) && !bus.busReady;

    mc_alu_decoder u_alu_dec (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Counter is held at zero outside the MEM states, so it is already
    // clear on the first MEM cycle. It never passes TMO_LAST because the
    // FSM leaves the MEM state on that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (is_mem_state(state)) begin
            if (!bus.busReady) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_comb begin
        state_n           = state;
        bus.regFileWe     = 1'b0;
        bus.aluControl    = ADD;
        bus.aluSrcMuxSel  = 1'b0;
        bus.RFWDSrcMuxSel = RFWD_ALU;
        bus.RD1MuxSel     = 1'b0;
        bus.branch        = 1'b0;
        bus.jump          = 1'b0;
        bus.jalr          = 1'b0;
        bus.pcEn          = 1'b0;
        bus.busReq        = 1'b0;
        bus.busWe         = 1'b0;
        bus.illegalInstr  = 1'b0;
        bus.busError      = 1'b0;

        case (state)
            FETCH: state_n = DECODE;

            DECODE: begin
                case (opcode)
                    OP_TYPE_R:  state_n = R_EXE;
                    OP_TYPE_I:  state_n = I_EXE;
                    OP_TYPE_B:  state_n = B_EXE;
                    OP_TYPE_LU: state_n = LU_EXE;
                    OP_TYPE_AU: state_n = AU_EXE;
                    OP_TYPE_J:  state_n = J_EXE;
                    OP_TYPE_JL: state_n = JL_EXE;
                    OP_TYPE_S:  state_n = S_EXE;
                    OP_TYPE_L:  state_n = L_EXE;
                    default: begin
                        bus.illegalInstr = 1'b1;
                        bus.pcEn         = 1'b1;
                        state_n          = FETCH;
                    end
                endcase
            end

            R_EXE: begin
                bus.regFileWe  = 1'b1;
                bus.aluControl = dec_alu;
                bus.pcEn       = 1'b1;
                state_n        = FETCH;
            end

            I_EXE: begin
                bus.regFileWe    = 1'b1;
                bus.aluSrcMuxSel = 1'b1;
                bus.aluControl   = dec_alu;
                bus.pcEn         = 1'b1;
                state_n          = FETCH;
            end

            B_EXE: begin
                bus.branch     = 1'b1;
                bus.aluControl = dec_alu;
                bus.pcEn       = 1'b1;
                state_n        = FETCH;
            end

            LU_EXE: begin
                bus.regFileWe    = 1'b1;
                bus.RD1MuxSel    = 1'b1;
                bus.aluSrcMuxSel = 1'b1;
                bus.aluControl   = ADD;
                bus.pcEn         = 1'b1;
                state_n          = FETCH;
            end

            AU_EXE: begin
                bus.regFileWe     = 1'b1;
                bus.RFWDSrcMuxSel = RFWD_PC_IMM;
                bus.pcEn          = 1'b1;
                state_n           = FETCH;
            end

            J_EXE: begin
                bus.regFileWe     = 1'b1;
                bus.RFWDSrcMuxSel = RFWD_PC_4;
                bus.jump          = 1'b1;
                bus.pcEn          = 1'b1;
                state_n           = FETCH;
            end

            JL_EXE: begin
                bus.regFileWe     = 1'b1;
                bus.RFWDSrcMuxSel = RFWD_PC_4;
                bus.jalr          = 1'b1;
                bus.aluSrcMuxSel  = 1'b1;
                bus.aluControl    = ADD;
                bus.pcEn          = 1'b1;
                state_n           = FETCH;
            end

            // Address (rs1 + imm) is held stable through every memory state.
            S_EXE: begin
                bus.aluSrcMuxSel = 1'b1;
                bus.aluControl   = ADD;
                state_n          = S_MEM;
            end

            S_MEM: begin
                bus.aluSrcMuxSel = 1'b1;
                bus.aluControl   = ADD;
                bus.busReq       = 1'b1;
                bus.busWe        = 1'b1;
                if (bus.busReady) begin
                    bus.pcEn = 1'b1;
                    state_n  = FETCH;
                end else if (timeout) begin
                    bus.busError = 1'b1;
                    bus.pcEn     = 1'b1;
                    state_n      = FETCH;
                end
            end

            L_EXE: begin
                bus.aluSrcMuxSel = 1'b1;
                bus.aluControl   = ADD;
                state_n          = L_MEM;
            end

            L_MEM: begin
                bus.aluSrcMuxSel = 1'b1;
                bus.aluControl   = ADD;
                bus.busReq       = 1'b1;
                if (bus.busReady) begin
                    state_n = L_WB;
                end else if (timeout) begin
                    // Aborted load: no write-back, move on to the next PC.
                    bus.busError = 1'b1;
                    bus.pcEn     = 1'b1;
                    state_n      = FETCH;
                end
            end

            L_WB: begin
                bus.aluSrcMuxSel  = 1'b1;
                bus.aluControl    = ADD;
                bus.regFileWe     = 1'b1;
                bus.RFWDSrcMuxSel = RFWD_BUS;
                bus.pcEn          = 1'b1;
                state_n           = FETCH;
            end

            default: state_n = FETCH;
        endcase
    end

endmodule
